etm_mult_seq: RTL and testbench
===============================

ETM_MULT_SEQ -- requirements
Module: etm_mult_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand width; even, at least 4.
REQ-002 SHALL have localparam H = WIDTH/2: the width of the split between the accurate high half and the approximate low half.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port a_i, input, WIDTH bits: multiplicand, unsigned.
REQ-006 SHALL have port b_i, input, WIDTH bits: multiplier, unsigned.
REQ-007 SHALL have port valid_i, input, 1 bit: operands valid.
REQ-008 SHALL have port ready_o, output, 1 bit: block can accept operands.
REQ-009 SHALL have port p_o, output, 2*WIDTH bits: product, registered.
REQ-010 SHALL have port valid_o, output, 1 bit: p_o valid.
REQ-011 SHALL have port ready_i, input, 1 bit: consumer accepts p_o.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, DONE.
REQ-013 In IDLE, ready_o SHALL be 1; in CALC and DONE, ready_o SHALL be 0.
REQ-014 On valid_i&&ready_o, SHALL register a_i and b_i, clear the accumulator and step counter, and go to CALC.
REQ-015 On the same accept edge, SHALL register mode: EXACT_LO if a_i[WIDTH-1:H]==0 and b_i[WIDTH-1:H]==0, else SPLIT.
REQ-016 EXACT_LO SHALL produce p_o = a_lo*b_lo exactly, computed by H-bit shift-add.
REQ-017 SPLIT SHALL produce p_o[2W-1:W] = a_hi*b_hi, computed exactly by H-bit shift-add.
REQ-018 SPLIT SHALL produce p_o[W-1:0] = ETM imprecise result of (a_lo, b_lo).
REQ-019 ETM imprecise rule: scan from MSB; each bit is the OR of the operand bits at that position and all more-significant positions; once the upper half of the result is formed, all lower bits copy the lowest upper bit.
REQ-020 CALC SHALL process one multiplier bit per cycle for exactly H cycles, then go to DONE.
REQ-021 p_o SHALL be updated only on the CALC-to-DONE transition.
REQ-022 valid_o SHALL rise H+1 cycles after the accept edge and SHALL equal 1 only in DONE.
REQ-023 In DONE, p_o and valid_o SHALL hold stable while ready_i=0.
REQ-024 In DONE with ready_i=1, SHALL go to IDLE; no same-cycle restart is allowed.
REQ-025 valid_i SHALL be ignored outside IDLE; a_i and b_i are sampled only at accept.
REQ-026 All arithmetic SHALL be unsigned with no overflow; the accumulator SHALL be 2*WIDTH bits.

Reset
REQ-027 When rst_ni=0 at a clock edge, SHALL enter IDLE and clear p_o, valid_o, the accumulator, the counter and the mode register.
REQ-028 Reset mid-CALC or in DONE SHALL abort the operation with no partial result ever presented.
REQ-029 The first cycle after reset release SHALL have ready_o=1.

Configuration
REQ-030 Macro ETM_EXACT_EN: when defined, SHALL add port exact_i (input, 1 bit, sampled at accept).
REQ-031 With ETM_EXACT_EN defined and exact_i=1, SHALL compute the full exact WIDTHxWIDTH product in WIDTH CALC cycles, so valid_o rises WIDTH+1 cycles after accept.
REQ-032 Without ETM_EXACT_EN, exact_i SHALL be absent and only the EXACT_LO and SPLIT modes SHALL exist.

Structure
REQ-033 Package etm_pkg SHALL hold the FSM state enum, the mode enum (EXACT_LO, SPLIT, EXACT_FULL) and the default WIDTH constant.
REQ-034 The approximate low part SHALL come from one instance of the existing etm sub-module, with N=H, driven by the registered low halves.
REQ-035 The sequential datapath SHALL NOT be shared with the etm instance.

Verification (WIDTH=8, H=4)
REQ-036 Input a=0x0B, b=0x07 -> EXACT_LO; p_o=0x004D; valid_o rises 5 cycles after accept.
REQ-037 Input a=0x35, b=0x42 -> SPLIT; high part 0x0C, etm(5,2)=0x7F; p_o=0x0C7F.
REQ-038 Input a=0xF0, b=0x01 -> SPLIT; high part 0x00, etm(0,1)=0x1F; p_o=0x001F.
REQ-039 Hold ready_i=0 for 10 cycles in DONE -> p_o and valid_o stable; then ready_i=1 -> IDLE next cycle and ready_o=1.
REQ-040 Assert rst_ni=0 at CALC cycle 2 -> p_o=0 and valid_o=0 next cycle; a new operation afterwards returns the correct product.
REQ-041 With ETM_EXACT_EN: a=0x35, b=0x42, exact_i=1 -> p_o=0x0DAA; valid_o rises 9 cycles after accept.

Source files
------------

// File: rtl/etm_pkg.sv
// rtl/etm_pkg.sv - shared types and constants for the sequential ETM multiplier
//
// Holds the controller state enum, the operating-mode enum and the default
// operand width used by etm_mult_seq.
package etm_pkg;

  localparam int ETM_WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // EXACT_LO   : both high halves zero, exact low-half product
  // SPLIT      : exact high-half product over an ETM-approximated low half
  // EXACT_FULL : full WIDTHxWIDTH product (only reachable with ETM_EXACT_EN)
  typedef enum logic [1:0] {
    EXACT_LO   = 2'd0,
    SPLIT      = 2'd1,
    EXACT_FULL = 2'd2
  } mode_t;

endpackage

// File: rtl/etm.sv
// rtl/etm.sv - combinational error-tolerant (non-multiplying) approximate product
//
// Ports:
//   a_i [N-1:0]   operand a, unsigned
//   b_i [N-1:0]   operand b, unsigned
//   p_o [2N-1:0]  approximate product
//
// Upper half: bit i is the OR of every operand bit at position i and above,
// i.e. ones from the most significant set bit downwards. Lower half: every
// bit copies the lowest bit of the upper half.
module etm #(
  parameter int N = 4
) (
  input  logic [N-1:0]   a_i,
  input  logic [N-1:0]   b_i,
  output logic [2*N-1:0] p_o
);

  logic [N-1:0] hi;
  logic         run;

  always_comb begin
    hi  = '0;
    run = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      run   = run | a_i[i] | b_i[i];
      hi[i] = run;
    end
    p_o = {hi, {N{hi[0]}}};
  end

endmodule

// File: rtl/etm_mult_seq.sv
// rtl/etm_mult_seq.sv - sequential shift-add multiplier with ETM low-half approximation
//
// Ports:
//   clk_i            clock, rising edge
//   rst_ni           synchronous active-low reset
//   a_i, b_i         unsigned operands (WIDTH bits), sampled on accept
//   valid_i/ready_o  operand handshake; ready_o high only in IDLE
//   p_o              registered product (2*WIDTH bits)
//   valid_o/ready_i  result handshake; valid_o high only in DONE
//   exact_i          (only with ETM_EXACT_EN) request full exact product
//
// Optional feature macro: ETM_EXACT_EN adds exact_i and the EXACT_FULL mode.
module etm_mult_seq
  import etm_pkg::*;
#(
  parameter int WIDTH = ETM_WIDTH_DEFAULT
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic               valid_i,
  output logic               ready_o,
  output logic [2*WIDTH-1:0] p_o,
  output logic               valid_o,
  input  logic               ready_i
`ifdef ETM_EXACT_EN
  ,
  input  logic               exact_i
`endif
);

  localparam int H  = WIDTH / 2;
  localparam int CW = $clog2(WIDTH) + 1;

  state_t             state_q, state_d;
  mode_t              mode_q, mode_in;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q, acc_next;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [H-1:0]       a_lo_q, b_lo_q;
  logic [2*WIDTH-1:0] etm_p;
  logic [CW-1:0]      last_cnt;
  logic               last_step;
  logic               accept;
  logic               full_sel;

`ifdef ETM_EXACT_EN
  assign full_sel = exact_i;
`else
  assign full_sel = 1'b0;
`endif

  assign accept = valid_i && (state_q == IDLE);

  always_comb begin
    if (full_sel) begin
      mode_in = EXACT_FULL;
    end else if ((a_i[WIDTH-1:H] == '0) && (b_i[WIDTH-1:H] == '0)) begin
      mode_in = EXACT_LO;
    end else begin
      mode_in = SPLIT;
    end
  end

  // Approximate low part, fed only by the registered low halves.
  etm #(.N(H)) u_etm (
    .a_i (a_lo_q),
    .b_i (b_lo_q),
    .p_o (etm_p[WIDTH-1:0])
  );
  assign etm_p[2*WIDTH-1:WIDTH] = '0;

  assign last_cnt  = (mode_q == EXACT_FULL) ? CW'(WIDTH - 1) : CW'(H - 1);
  assign last_step = (cnt_q == last_cnt);
  assign acc_next  = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d = state_q;
    ready_o = 1'b0;
    valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (valid_i) state_d = CALC;
      end
      CALC: begin
        if (last_step) state_d = DONE;
      end
      DONE: begin
        valid_o = 1'b1;
        if (ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mode_q   <= EXACT_LO;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      a_lo_q   <= '0;
      b_lo_q   <= '0;
      p_o      <= '0;
    end else if (accept) begin
      mode_q <= mode_in;
      cnt_q  <= '0;
      acc_q  <= '0;
      a_lo_q <= a_i[H-1:0];
      b_lo_q <= b_i[H-1:0];
      // The shift-add operands depend on mode: SPLIT multiplies the high
      // halves, the exact modes multiply the low halves or full operands.
      case (mode_in)
        SPLIT: begin
          mcand_q  <= {{(2*WIDTH-H){1'b0}}, a_i[WIDTH-1:H]};
          mplier_q <= {{(WIDTH-H){1'b0}}, b_i[WIDTH-1:H]};
        end
        EXACT_FULL: begin
          mcand_q  <= {{WIDTH{1'b0}}, a_i};
          mplier_q <= b_i;
        end
        default: begin
          mcand_q  <= {{(2*WIDTH-H){1'b0}}, a_i[H-1:0]};
          mplier_q <= {{(WIDTH-H){1'b0}}, b_i[H-1:0]};
        end
      endcase
    end else if (state_q == CALC) begin
      acc_q    <= acc_next;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CW'(1);
      if (last_step) begin
        if (mode_q == SPLIT) begin
          p_o <= {acc_next[WIDTH-1:0], etm_p[WIDTH-1:0]};
        end else begin
          p_o <= acc_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_etm_mult_seq.sv
// tb/tb_etm_mult_seq.sv - randomized self-checking bench for etm_mult_seq (WIDTH=8)
module tb_etm_mult_seq;

  localparam int W = 8;
  localparam int H = W / 2;

  logic           clk;
  logic           rst_ni;
  logic [W-1:0]   a_i, b_i;
  logic           valid_i;
  logic           ready_o;
  logic [2*W-1:0] p_o;
  logic           valid_o;
  logic           ready_i;
  logic           exact_i;

  int errs;
  int n_checks;
  logic [2*W-1:0] prev_p;

  etm_mult_seq #(.WIDTH(W)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_ni),
    .a_i     (a_i),
    .b_i     (b_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .p_o     (p_o),
    .valid_o (valid_o),
    .ready_i (ready_i)
`ifdef ETM_EXACT_EN
    ,
    .exact_i (exact_i)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: ETM approximation from the most significant set bit of a|b.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic ex);
    int unsigned v, msb, hi, lo;
    if (ex) return 16'(int'(a) * int'(b));
    if ((a >> H) == 0 && (b >> H) == 0) return 16'(int'(a) * int'(b));
    hi = (int'(a) >> H) * (int'(b) >> H);
    v  = (int'(a) | int'(b)) % (1 << H);
    if (v == 0) begin
      lo = 0;
    end else begin
      msb = 0;
      for (int i = 0; i < H; i++) if ((v >> i) % 2 == 1) msb = i;
      lo = ((((1 << (msb + 1)) - 1)) << H) | ((1 << H) - 1);
    end
    return 16'((hi << W) | lo);
  endfunction

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ex,
                       input int hold);
    int lat;
    logic [2*W-1:0] exp_p;
    exp_p = model(a, b, ex);
    check("ready_idle", ready_o, 1);
    a_i = a; b_i = b; exact_i = ex; valid_i = 1'b1;
    @(negedge clk);
    // Garbage on operand inputs and valid_i while busy must be ignored.
    a_i = W'($urandom); b_i = W'($urandom); exact_i = 1'($urandom);
    check("ready_busy", ready_o, 0);
    lat = 1;
    while (!valid_o && lat < 40) begin
      check("p_hold_calc", p_o, prev_p);
      @(negedge clk);
      lat++;
    end
    valid_i = 1'b0;
    check("latency", lat, ex ? W + 1 : H + 1);
    check("product", p_o, exp_p);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_p", p_o, exp_p);
      check("hold_valid", valid_o, 1);
    end
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
    check("back_idle_ready", ready_o, 1);
    check("back_idle_valid", valid_o, 0);
    prev_p = exp_p;
  endtask

  initial begin
    logic [W-1:0] a, b;
    logic ex;
    errs = 0; n_checks = 0; prev_p = '0;
    rst_ni = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    a_i = '0; b_i = '0; exact_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_p", p_o, 0);
    check("rst_valid", valid_o, 0);
    rst_ni = 1'b1;
    @(negedge clk);
    check("rst_release_ready", ready_o, 1);

    do_op(8'h0B, 8'h07, 1'b0, 0);
    do_op(8'h35, 8'h42, 1'b0, 0);
    do_op(8'hF0, 8'h01, 1'b0, 10);
`ifdef ETM_EXACT_EN
    do_op(8'h35, 8'h42, 1'b1, 2);
`endif

    // Reset during CALC cycle 2 aborts without presenting a result.
    a_i = 8'h35; b_i = 8'h42; exact_i = 1'b0; valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    @(negedge clk);
    rst_ni = 1'b0;
    @(negedge clk);
    check("abort_p", p_o, 0);
    check("abort_valid", valid_o, 0);
    rst_ni = 1'b1;
    @(negedge clk);
    check("abort_ready", ready_o, 1);
    prev_p = '0;
    do_op(8'hC3, 8'h5A, 1'b0, 1);

    for (int n = 0; n < 40; n++) begin
      a = W'($urandom);
      b = W'($urandom);
      if (n % 3 == 0) begin
        a = a % (1 << H);
        b = b % (1 << H);
      end
`ifdef ETM_EXACT_EN
      ex = 1'($urandom);
`else
      ex = 1'b0;
`endif
      do_op(a, b, ex, int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errs, n_checks);
    $finish;
  end

endmodule
